branch_resolve_queue: RTL
=========================

# branch_resolve_queue

Execute-side counterpart of the fetch predictor. Records each fetched control-transfer instruction's PC and predicted next PC in a tagged circular queue, accepts out-of-order branch resolutions from the ALU, and compares actual against predicted outcome. Produces the registered mispredict/redirect pulse and the BTB update that drive the predictor. Sits between IF/DC (allocation), EX (resolution) and the BPU (redirect + training).

## Interface
- DEPTH, 4, number of in-flight branch entries; power of two, ≥2
- TAG_W, $clog2(DEPTH), width of branch tag
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline-wide flush (exception/trap); empties queue
- alloc_valid  in  1  decode has a branch/jump to record
- alloc_pc  in  32  PC of that instruction
- alloc_pred_pc  in  32  next PC the predictor chose for it
- alloc_ready  out  1  queue not full (combinational from pointers)
- alloc_tag  out  TAG_W  tag assigned to the allocating instruction (tail index)
- res_valid  in  1  EX resolves one branch this cycle
- res_tag  in  TAG_W  tag of resolving branch
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- mispredict  out  1  registered one-cycle redirect pulse
- redirect_pc  out  32  correct next PC for the mispredicted branch
- btb_upd_valid  out  1  registered one-cycle BTB write pulse
- btb_upd_pc  out  32  PC to train
- btb_upd_target  out  32  actual next PC to store
- empty  out  1  no live entries

## Operation
- Storage per entry: pc[31:0], pred[31:0], live, done. Head/tail pointers TAG_W+1 bits; index = low TAG_W bits; full when indices equal and MSBs differ; empty when pointers equal.
- Allocate: alloc_valid && alloc_ready → entry[tail] = {alloc_pc, alloc_pred_pc, live=1, done=0}; tail+1 (wraps modulo 2·DEPTH). alloc_valid while full: dropped, no state change.
- Resolve: accepted only if res_valid and entry[res_tag].live and !done; otherwise ignored (stale tag after flush). actual = res_taken ? res_target : pc+4 (32-bit wrap). Set done=1.
- Accepted resolve always emits btb_upd_valid with btb_upd_pc=pc, btb_upd_target=actual.
- actual ≠ pred → mispredict=1, redirect_pc=actual; all entries younger than res_tag: live=0; tail = pointer of res_tag + 1 (resolving entry retained).
- Retire: if entry[head].live && done → live=0, head+1. At most one retire per cycle.
- Retire, allocate, resolve may all occur in one cycle. Mispredict in cycle N overrides a same-cycle allocate (allocation discarded, alloc_tag not consumed).
- flush: all live=0, head=tail=0; outputs mispredict/btb_upd_valid forced 0 next cycle. flush dominates everything including a same-cycle resolve.

## Timing
- Reset: head=tail=0, all live/done=0, mispredict=0, redirect_pc=0, btb_upd_valid=0, btb_upd_pc=0, btb_upd_target=0, alloc_ready=1, alloc_tag=0, empty=1.
- Allocation visible at next edge; the same entry may be resolved the cycle after allocation.
- Resolve in cycle N → mispredict/redirect_pc and btb_upd_* valid in N+1 for exactly one cycle.
- Flush-from-mispredict applies at end of N; alloc_ready/alloc_tag in N+1 reflect rolled-back tail.
- Retire of a resolved head occurs on the edge after done is set (head pops in N+1 earliest); alloc_ready rises combinationally the cycle after the pop.
- rst mid-operation: all state returns to reset values on that edge; pending outputs cleared.

## Test plan
- Reset then 4 allocs (pc 0x100/0x104/0x108/0x10C, pred = pc+4) → tags 0..3, alloc_ready=0 after 4th; 5th alloc dropped, tail unchanged.
- Resolve tag 1 not-taken (actual 0x108 = pred) → N+1: mispredict=0, btb_upd_valid=1, pc 0x104, target 0x108; no retire until tag 0 resolved, then tags 0 and 1 retire on consecutive cycles.
- Alloc 0x200 pred 0x204, 0x204, 0x208; resolve tag of 0x200 taken target 0x400 → N+1 mispredict=1, redirect_pc=0x400; next alloc_tag = resolved tag+1; later resolve of killed tag ignored (no outputs).
- Resolve with simultaneous alloc causing mispredict → alloc discarded, tail = resolved+1.
- Wrap-around: 10 alloc/resolve/retire cycles with DEPTH=4 → tags wrap 3→0, full/empty correct, no spurious mispredict.
- flush with 3 live entries and same-cycle resolve → empty=1 next cycle, mispredict=0, btb_upd_valid=0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - tagged circular queue of in-flight branches with out-of-order resolution
// Emits registered mispredict/redirect and BTB training pulses; rolls back the tail on mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [31:0]      alloc_pc,
    input  logic [31:0]      alloc_pred_pc,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             btb_upd_valid,
    output logic [31:0]      btb_upd_pc,
    output logic [31:0]      btb_upd_target,
    output logic             empty
);

    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    logic [TAG_W:0]   head_q, head_d, tail_q, tail_d;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pred_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d, done_q, done_d;

    logic        mis_q, mis_d;
    logic [31:0] redirect_q, redirect_d;
    logic        btb_valid_q, btb_valid_d;
    logic [31:0] btb_pc_q, btb_pc_d;
    logic [31:0] btb_tgt_q, btb_tgt_d;

    logic [TAG_W-1:0] head_idx, tail_idx, res_off;
    logic [TAG_W:0]   res_ptr;
    logic             full, retire, res_accept, res_mis, alloc_fire;
    logic [31:0]      res_pc, res_pred, actual;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

    assign alloc_ready    = !full;
    assign alloc_tag      = tail_idx;
    assign empty          = (head_q == tail_q);
    assign mispredict     = mis_q;
    assign redirect_pc    = redirect_q;
    assign btb_upd_valid  = btb_valid_q;
    assign btb_upd_pc     = btb_pc_q;
    assign btb_upd_target = btb_tgt_q;

    assign res_pc     = pc_q[res_tag];
    assign res_pred   = pred_q[res_tag];
    assign actual     = res_taken ? res_target : res_pc + 32'd4;
    assign res_accept = res_valid && live_q[res_tag] && !done_q[res_tag];
    assign res_mis    = res_accept && (actual != res_pred);

    // Live entries sit in [head, tail), so the resolving tag's full pointer is head plus its age.
    assign res_off = res_tag - head_idx;
    assign res_ptr = head_q + {1'b0, res_off};

    assign retire     = live_q[head_idx] && done_q[head_idx];
    assign alloc_fire = alloc_valid && !full && !res_mis && !flush;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        live_d      = live_q;
        done_d      = done_q;
        mis_d       = 1'b0;
        redirect_d  = redirect_q;
        btb_valid_d = 1'b0;
        btb_pc_d    = btb_pc_q;
        btb_tgt_d   = btb_tgt_q;

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            live_d = '0;
            done_d = '0;
        end else begin
            if (retire) begin
                live_d[head_idx] = 1'b0;
                head_d           = head_q + PTR_ONE;
            end
            if (res_accept) begin
                done_d[res_tag] = 1'b1;
                btb_valid_d     = 1'b1;
                btb_pc_d        = res_pc;
                btb_tgt_d       = actual;
                if (res_mis) begin
                    mis_d      = 1'b1;
                    redirect_d = actual;
                    tail_d     = res_ptr + PTR_ONE;
                    // Kill everything allocated after the mispredicted branch.
                    for (int i = 0; i < DEPTH; i++) begin
                        if ((TAG_W'(i) - head_idx) > res_off)
                            live_d[i] = 1'b0;
                    end
                end
            end
            if (alloc_fire) begin
                live_d[tail_idx] = 1'b1;
                done_d[tail_idx] = 1'b0;
                tail_d           = tail_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            live_q      <= '0;
            done_q      <= '0;
            mis_q       <= 1'b0;
            redirect_q  <= '0;
            btb_valid_q <= 1'b0;
            btb_pc_q    <= '0;
            btb_tgt_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            live_q      <= live_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            redirect_q  <= redirect_d;
            btb_valid_q <= btb_valid_d;
            btb_pc_q    <= btb_pc_d;
            btb_tgt_q   <= btb_tgt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && alloc_fire) begin
            pc_q[tail_idx]   <= alloc_pc;
            pred_q[tail_idx] <= alloc_pred_pc;
        end
    end

endmodule
